mnist_frame_streamer: RTL and testbench
=======================================

// Module: mnist_frame_streamer
// PURPOSE
//  Upstream feeder for the MLP inference core. Accepts a 28x28 greyscale image as a
//  valid/ready byte stream and stores it in a local frame buffer. Replays it as one
//  gap-free burst of pixel_in/input_en beats, then waits for the core's output_en.
//  Returns the captured inference_index through a valid/ready result port.
// PARAMETERS
//  NUM_PIXELS      784   pixels per frame; frame buffer depth; counter range 0..NUM_PIXELS-1
//  PIX_W           8     pixel width, unsigned greyscale
//  IDX_W           4     inference index width
//  TIMEOUT_CYCLES  4096  WAIT-state watchdog limit; used only when MNIST_STREAM_TIMEOUT_EN is defined
// PORTS
//  clk            in   1      single clock, all logic posedge
//  rst_n          in   1      asynchronous, active-low reset
//  s_valid        in   1      input pixel byte valid
//  s_data         in   PIX_W  input pixel byte, raster order, pixel 0 first
//  s_last         in   1      marks last byte of frame
//  s_ready        out  1      streamer accepts a byte this cycle
//  mlp_input_en   out  1      to core input_en
//  mlp_pixel      out  PIX_W  to core pixel_in
//  mlp_output_en  in   1      from core output_en (level, sticky in core)
//  mlp_index      in   IDX_W  from core inference_index
//  res_valid      out  1      result available
//  res_index      out  IDX_W  inferred digit 0..9
//  res_ready      in   1      result consumer ready
//  res_timeout    out  1      result produced by watchdog; constant 0 without macro
//  frame_err      out  1      one-cycle pulse: malformed frame discarded
//  busy           out  1      high in every state except FILL
// BEHAVIOUR
//  Reset: async assert, sync deassert. FSM goes to FILL; wr_cnt/rd_cnt=0.
//   All outputs 0 except s_ready=1 one cycle after deassert.
//   Frame buffer contents are not cleared. Reset mid-burst aborts immediately:
//   mlp_input_en=0 asynchronously. A partial frame is lost.
//  FSM states FILL -> STREAM -> WAIT -> RESULT -> FILL.
//  FILL: s_ready=1. Each s_valid&s_ready beat writes buf[wr_cnt] and increments wr_cnt.
//   Beat at wr_cnt==NUM_PIXELS-1 with s_last=1: frame complete, go STREAM.
//   s_last=1 before that, or s_last=0 on the final beat: pulse frame_err, wr_cnt=0, stay FILL.
//  STREAM: s_ready=0. Buffer read is registered (1-cycle latency).
//   Last FILL beat at cycle T: mlp_input_en=1 on cycles T+2..T+1+NUM_PIXELS, never gapped.
//   mlp_pixel=buf[k] on cycle T+2+k. Outside the burst, mlp_input_en=0 and mlp_pixel=0.
//   After the final beat go WAIT.
//  WAIT: a registered edge detector (prev reset 0) watches mlp_output_en from STREAM entry.
//   First 0->1 transition, or a level already 1 at WAIT entry, latches mlp_index into res_index.
//   Then go RESULT.
//  RESULT: res_valid=1, holding res_index/res_timeout stable until res_valid&res_ready.
//   On that handshake: res_valid=0 next cycle, go FILL, wr_cnt=0.
//   s_valid during STREAM/WAIT/RESULT is back-pressured, never dropped.
//  Counters: clog2(NUM_PIXELS) bits. No wrap past NUM_PIXELS-1; each count is cleared explicitly.
//  res_index is a plain register copy; values >9 are passed through unmodified.
// CONFIGURATION
//  MNIST_STREAM_TIMEOUT_EN defined: WAIT counts cycles.
//   At TIMEOUT_CYCLES without output_en: res_index=4'hF, res_timeout=1, go RESULT.
//   Counter clears on WAIT entry.
//  Not defined: no counter. WAIT holds indefinitely. res_timeout tied 0.
// TESTING
//  1 Reset then 784 beats (pixel k=k[7:0], s_last on beat 783, s_valid constant)
//    -> 784 consecutive input_en cycles, pixel sequence 00,01..FF,00..0F, first beat 2 cycles after last accept.
//  2 Core model raises output_en with index 7, res_ready=1
//    -> res_valid one cycle, res_index=7, res_timeout=0, s_ready=1 next cycle.
//  3 s_last on beat 100 -> frame_err single pulse, no input_en.
//    Next full frame streams correctly; same for missing s_last on beat 783.
//  4 s_valid with random gaps (~50% duty) during FILL -> burst still contiguous 784 cycles, data matches.
//  5 rst_n low at burst beat 300 -> input_en=0 same cycle, FSM FILL after release.
//    Re-sent frame streams fully from pixel 0.
//  6 MACRO on, TIMEOUT_CYCLES=16, output_en never rises -> res_valid after 16 WAIT cycles, index=F, res_timeout=1.
//    MACRO off -> res_valid stays 0 for 10000 cycles.
//  Hold res_ready=0 for 50 cycles in RESULT -> res_valid/res_index stable, s_ready=0 throughout.

Source files
------------

// File: rtl/mnist_frame_streamer.sv
// mnist_frame_streamer
//   Front end for the MLP inference core. A 28x28 greyscale frame arrives as a
//   valid/ready byte stream and is stored in a local frame buffer. Once the
//   frame is complete it is replayed to the core as one gap-free burst of
//   mlp_input_en/mlp_pixel beats. The streamer then waits for the core's
//   output_en and returns the captured index on a valid/ready result port.
//
//   Ports
//     clk, rst_n             clock, asynchronous active-low reset
//     s_valid/s_data/s_last  pixel byte stream in, raster order
//     s_ready                byte accepted this cycle (FILL only)
//     mlp_input_en/mlp_pixel burst to the core
//     mlp_output_en/mlp_index  core result (output_en is a sticky level)
//     res_valid/res_index/res_ready  result handshake
//     res_timeout            result came from the watchdog
//     frame_err              one-cycle pulse, malformed frame discarded
//     busy                   high in every state except FILL
//
//   Build option: define MNIST_STREAM_TIMEOUT_EN to enable the WAIT watchdog
//   (TIMEOUT_CYCLES). Without it WAIT holds indefinitely and res_timeout is 0.
module mnist_frame_streamer #(
    parameter int NUM_PIXELS     = 784,
    parameter int PIX_W          = 8,
    parameter int IDX_W          = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    input  logic [PIX_W-1:0] s_data,
    input  logic             s_last,
    output logic             s_ready,
    output logic             mlp_input_en,
    output logic [PIX_W-1:0] mlp_pixel,
    input  logic             mlp_output_en,
    input  logic [IDX_W-1:0] mlp_index,
    output logic             res_valid,
    output logic [IDX_W-1:0] res_index,
    input  logic             res_ready,
    output logic             res_timeout,
    output logic             frame_err,
    output logic             busy
);
    localparam int               CNT_W = $clog2(NUM_PIXELS);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(NUM_PIXELS - 1);

    typedef enum logic [1:0] {S_FILL, S_STREAM, S_WAIT, S_RESULT} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
    logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
    logic [PIX_W-1:0] frame_buf [NUM_PIXELS];
    logic [PIX_W-1:0] pix_q;
    logic             en_q;
    logic             rdy_q;         // holds s_ready low for the first cycle out of reset
    logic             prev_q;        // output_en edge-detector history
    logic             wait_entry_q;  // first cycle of WAIT
    logic             err_q, err_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             beat;
    logic             trig;

    assign beat = s_valid & s_ready;
    // A rising edge, or a level that was already high when WAIT was entered
    // (the core raised output_en during the burst).
    assign trig = mlp_output_en & (~prev_q | wait_entry_q);

`ifdef MNIST_STREAM_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] to_cnt_q;
    logic            to_q, to_d;
    logic            to_hit;

    assign to_hit = (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

    // Cleared outside WAIT, so every WAIT entry starts from zero; WAIT is
    // left on to_hit, so the counter never overflows.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_q <= '0;
            to_q     <= 1'b0;
        end else begin
            to_cnt_q <= (state_q == S_WAIT) ? to_cnt_q + 1'b1 : '0;
            to_q     <= to_d;
        end
    end
    assign res_timeout = to_q;
`else
    assign res_timeout = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        wr_cnt_d = wr_cnt_q;
        rd_cnt_d = rd_cnt_q;
        err_d    = 1'b0;
        idx_d    = idx_q;
`ifdef MNIST_STREAM_TIMEOUT_EN
        to_d     = to_q;
`endif
        case (state_q)
            S_FILL: begin
                if (beat) begin
                    if (wr_cnt_q == LAST) begin
                        wr_cnt_d = '0;
                        if (s_last) begin
                            state_d  = S_STREAM;
                            rd_cnt_d = '0;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else if (s_last) begin
                        wr_cnt_d = '0;
                        err_d    = 1'b1;
                    end else begin
                        wr_cnt_d = wr_cnt_q + 1'b1;
                    end
                end
            end
            S_STREAM: begin
                if (rd_cnt_q == LAST) begin
                    rd_cnt_d = '0;
                    state_d  = S_WAIT;
                end else begin
                    rd_cnt_d = rd_cnt_q + 1'b1;
                end
            end
            S_WAIT: begin
                if (trig) begin
                    idx_d   = mlp_index;
                    state_d = S_RESULT;
`ifdef MNIST_STREAM_TIMEOUT_EN
                    to_d    = 1'b0;
                end else if (to_hit) begin
                    idx_d   = {IDX_W{1'b1}};
                    to_d    = 1'b1;
                    state_d = S_RESULT;
`endif
                end
            end
            S_RESULT: begin
                if (res_ready) begin
                    state_d  = S_FILL;
                    wr_cnt_d = '0;
`ifdef MNIST_STREAM_TIMEOUT_EN
                    to_d     = 1'b0;
`endif
                end
            end
            default: state_d = S_FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_FILL;
            wr_cnt_q     <= '0;
            rd_cnt_q     <= '0;
            pix_q        <= '0;
            en_q         <= 1'b0;
            rdy_q        <= 1'b0;
            prev_q       <= 1'b0;
            wait_entry_q <= 1'b0;
            err_q        <= 1'b0;
            idx_q        <= '0;
        end else begin
            state_q      <= state_d;
            wr_cnt_q     <= wr_cnt_d;
            rd_cnt_q     <= rd_cnt_d;
            rdy_q        <= 1'b1;
            // Registered buffer read: the burst trails the read address by one.
            en_q         <= (state_q == S_STREAM);
            pix_q        <= (state_q == S_STREAM) ? frame_buf[rd_cnt_q] : '0;
            prev_q       <= (state_q == S_STREAM || state_q == S_WAIT) ? mlp_output_en : 1'b0;
            wait_entry_q <= (state_q == S_STREAM) && (state_d == S_WAIT);
            err_q        <= err_d;
            idx_q        <= idx_d;
        end
    end

    // Frame buffer has no reset; contents survive reset.
    always_ff @(posedge clk) begin
        if (beat) frame_buf[wr_cnt_q] <= s_data;
    end

    assign s_ready      = rdy_q & (state_q == S_FILL);
    assign busy         = (state_q != S_FILL);
    assign res_valid    = (state_q == S_RESULT);
    assign res_index    = idx_q;
    assign frame_err    = err_q;
    assign mlp_input_en = en_q;
    assign mlp_pixel    = pix_q;

endmodule

// File: tb/tb_mnist_frame_streamer.sv
// Directed bench for mnist_frame_streamer. Inputs are driven 1ns after the
// rising edge; a negedge monitor logs burst beats, accepts and frame_err pulses.
// Built with MNIST_STREAM_TIMEOUT_EN the DUT watchdog is 16 cycles.
`timescale 1ns/1ps
module tb_mnist_frame_streamer;
    localparam int NP = 784;
    localparam int CAPN = 16384;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       s_valid = 1'b0;
    logic [7:0] s_data = 8'h00;
    logic       s_last = 1'b0;
    logic       s_ready;
    logic       mlp_input_en;
    logic [7:0] mlp_pixel;
    logic       mlp_output_en = 1'b0;
    logic [3:0] mlp_index = 4'h0;
    logic       res_valid;
    logic [3:0] res_index;
    logic       res_ready = 1'b0;
    logic       res_timeout;
    logic       frame_err;
    logic       busy;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int ncap = 0;
    int nerr = 0;
    int last_acc = 0;
    logic [7:0] cap [CAPN];
    int         capcyc [CAPN];

    mnist_frame_streamer #(
        .NUM_PIXELS(NP), .PIX_W(8), .IDX_W(4), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
        .mlp_input_en(mlp_input_en), .mlp_pixel(mlp_pixel),
        .mlp_output_en(mlp_output_en), .mlp_index(mlp_index),
        .res_valid(res_valid), .res_index(res_index), .res_ready(res_ready),
        .res_timeout(res_timeout), .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (s_valid && s_ready) last_acc <= cyc;
        if (mlp_input_en && ncap < CAPN) begin
            cap[ncap]    <= mlp_pixel;
            capcyc[ncap] <= cyc;
            ncap         <= ncap + 1;
        end
        if (frame_err) nerr <= nerr + 1;
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0; s_valid = 1'b0; s_last = 1'b0;
        mlp_output_en = 1'b0; res_ready = 1'b0;
        repeat (2) tick();
        @(negedge clk) rst_n = 1'b1;
        tick();
    endtask

    task automatic send_frame(input int n, input int last_at, input int base, input bit gaps,
                              output bit ok);
        int  g;
        bit  acc;
        ok = 1'b1;
        for (int k = 0; k < n; k++) begin
            if (gaps) begin
                s_valid = 1'b0;
                repeat ($urandom_range(0, 1)) tick();
            end
            s_valid = 1'b1;
            s_data  = 8'(k + base);
            s_last  = (k == last_at);
            g = 0; acc = 1'b0;
            while (!acc && g < 2000) begin
                @(negedge clk); acc = s_ready;
                tick();
                g++;
            end
            if (!acc) begin ok = 1'b0; break; end
        end
        s_valid = 1'b0; s_last = 1'b0;
    endtask

    task automatic wait_burst_end(output bit ok);
        bit seen;
        seen = 1'b0; ok = 1'b0;
        for (int g = 0; g < 3000; g++) begin
            tick();
            if (mlp_input_en) seen = 1'b1;
            else if (seen) begin ok = 1'b1; break; end
        end
    endtask

    // Burst statistics only; the tests judge them.
    task automatic burst_stats(input int st, input int base, output int cnt, output int gaps,
                               output int dbad, output int lat);
        cnt = ncap - st; gaps = 0; dbad = 0; lat = -1;
        if (cnt > 0) lat = capcyc[st] - last_acc;
        for (int i = 0; i < cnt; i++) begin
            if (capcyc[st+i] != capcyc[st] + i) gaps++;
            if (cap[st+i] !== 8'(base + i)) dbad++;
        end
    endtask

    task automatic core_respond(input logic [3:0] idx, output int nrv, output logic [3:0] gidx,
                                output logic gto, output logic rdy_after);
        bit got;
        nrv = 0; gidx = 4'h0; gto = 1'b0; rdy_after = 1'b0; got = 1'b0;
        mlp_output_en = 1'b1; mlp_index = idx; res_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (res_valid) begin
                if (nrv == 0) begin gidx = res_index; gto = res_timeout; end
                nrv++;
            end else if (nrv > 0 && !got) begin
                rdy_after = s_ready; got = 1'b1;
            end
        end
        mlp_output_en = 1'b0; res_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) tick();
        if (s_ready !== 1'b0) begin n_bad++; $display("FAIL rst_s_ready: got %b want 0", s_ready); end
        n_cmp++;
        if (mlp_input_en !== 1'b0 || mlp_pixel !== 8'h00) begin
            n_bad++; $display("FAIL rst_burst: got en=%b pix=%h want 0/00", mlp_input_en, mlp_pixel);
        end
        n_cmp++;
        if ({res_valid, busy, frame_err, res_timeout} !== 4'b0000) begin
            n_bad++; $display("FAIL rst_outs: got %b want 0000", {res_valid, busy, frame_err, res_timeout});
        end
        n_cmp++;
        @(negedge clk) rst_n = 1'b1;
        #1;
        if (s_ready !== 1'b0) begin n_bad++; $display("FAIL rst_rel_s_ready: got %b want 0", s_ready); end
        n_cmp++;
        tick();
        if (s_ready !== 1'b1) begin n_bad++; $display("FAIL rst_next_s_ready: got %b want 1", s_ready); end
        n_cmp++;
    endtask

    task automatic check_good_frame(input string nm, input int base, input bit gaps);
        int st, cnt, gp, db, lat;
        bit ok, ok2;
        st = ncap;
        send_frame(NP, NP-1, base, gaps, ok);
        wait_burst_end(ok2);
        if ({ok, ok2} !== 2'b11) begin n_bad++; $display("FAIL %s_handshake: got %b want 11", nm, {ok, ok2}); end
        n_cmp++;
        burst_stats(st, base, cnt, gp, db, lat);
        if (cnt !== NP) begin n_bad++; $display("FAIL %s_count: got %0d want %0d", nm, cnt, NP); end
        n_cmp++;
        if (gp !== 0) begin n_bad++; $display("FAIL %s_gaps: got %0d want 0", nm, gp); end
        n_cmp++;
        if (db !== 0) begin n_bad++; $display("FAIL %s_data: got %0d bad pixels want 0", nm, db); end
        n_cmp++;
        if (lat !== 2) begin n_bad++; $display("FAIL %s_latency: got %0d want 2", nm, lat); end
        n_cmp++;
        if (busy !== 1'b1 || res_valid !== 1'b0) begin
            n_bad++; $display("FAIL %s_wait: got busy=%b rv=%b want 1/0", nm, busy, res_valid);
        end
        n_cmp++;
    endtask

    task automatic test_stream();
        int st;
        st = ncap;
        check_good_frame("stream", 0, 1'b0);
        if (cap[st] !== 8'h00 || cap[st+255] !== 8'hFF || cap[st+256] !== 8'h00 || cap[st+783] !== 8'h0F) begin
            n_bad++; $display("FAIL stream_marks: got %h %h %h %h want 00 ff 00 0f",
                              cap[st], cap[st+255], cap[st+256], cap[st+783]);
        end
        n_cmp++;
    endtask

    task automatic test_result(input logic [3:0] idx, input string nm);
        int nrv;
        logic [3:0] gi;
        logic gto, ra;
        core_respond(idx, nrv, gi, gto, ra);
        if (nrv !== 1) begin n_bad++; $display("FAIL %s_rv_cycles: got %0d want 1", nm, nrv); end
        n_cmp++;
        if (gi !== idx) begin n_bad++; $display("FAIL %s_index: got %h want %h", nm, gi, idx); end
        n_cmp++;
        if (gto !== 1'b0) begin n_bad++; $display("FAIL %s_timeout: got %b want 0", nm, gto); end
        n_cmp++;
        if (ra !== 1'b1) begin n_bad++; $display("FAIL %s_s_ready_after: got %b want 1", nm, ra); end
        n_cmp++;
    endtask

    task automatic test_frame_err();
        int e0, st;
        bit ok;
        e0 = nerr; st = ncap;
        send_frame(101, 100, 0, 1'b0, ok);
        repeat (5) tick();
        if (nerr - e0 !== 1) begin n_bad++; $display("FAIL err_early_pulses: got %0d want 1", nerr - e0); end
        n_cmp++;
        if (ncap - st !== 0 || busy !== 1'b0) begin
            n_bad++; $display("FAIL err_early_idle: got beats=%0d busy=%b want 0/0", ncap - st, busy);
        end
        n_cmp++;
        check_good_frame("err_recov1", 9, 1'b0);
        test_result(4'hC, "err_recov1");
        e0 = nerr; st = ncap;
        send_frame(NP, -1, 0, 1'b0, ok);
        repeat (5) tick();
        if (nerr - e0 !== 1) begin n_bad++; $display("FAIL err_nolast_pulses: got %0d want 1", nerr - e0); end
        n_cmp++;
        if (ncap - st !== 0 || busy !== 1'b0) begin
            n_bad++; $display("FAIL err_nolast_idle: got beats=%0d busy=%b want 0/0", ncap - st, busy);
        end
        n_cmp++;
        check_good_frame("err_recov2", 3, 1'b0);
        test_result(4'h2, "err_recov2");
    endtask

    task automatic test_gaps();
        check_good_frame("gaps", 77, 1'b1);
        test_result(4'h5, "gaps");
    endtask

    task automatic test_reset_mid_burst();
        bit ok;
        send_frame(NP, NP-1, 0, 1'b0, ok);
        repeat (301) @(posedge clk);
        #1;
        if (mlp_input_en !== 1'b1 || mlp_pixel !== 8'h2C) begin
            n_bad++; $display("FAIL abort_beat300: got en=%b pix=%h want 1/2c", mlp_input_en, mlp_pixel);
        end
        n_cmp++;
        rst_n = 1'b0;
        #1;
        if (mlp_input_en !== 1'b0 || mlp_pixel !== 8'h00) begin
            n_bad++; $display("FAIL abort_async: got en=%b pix=%h want 0/00", mlp_input_en, mlp_pixel);
        end
        n_cmp++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy: got %b want 0", busy); end
        n_cmp++;
        @(negedge clk) rst_n = 1'b1;
        tick();
        if (s_ready !== 1'b1) begin n_bad++; $display("FAIL abort_s_ready: got %b want 1", s_ready); end
        n_cmp++;
        check_good_frame("resend", 5, 1'b0);
    endtask

    // Entered in WAIT after the resent frame.
    task automatic test_result_hold();
        int bad, g;
        mlp_output_en = 1'b1; mlp_index = 4'h3; res_ready = 1'b0;
        g = 0;
        while (!res_valid && g < 20) begin tick(); g++; end
        if (res_valid !== 1'b1) begin n_bad++; $display("FAIL hold_rv: got %b want 1", res_valid); end
        n_cmp++;
        s_valid = 1'b1; s_data = 8'hAA;
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (res_valid !== 1'b1 || res_index !== 4'h3 || s_ready !== 1'b0 || res_timeout !== 1'b0) bad++;
        end
        if (bad !== 0) begin n_bad++; $display("FAIL hold_stable: got %0d unstable cycles want 0", bad); end
        n_cmp++;
        s_valid = 1'b0; res_ready = 1'b1; mlp_output_en = 1'b0;
        tick();
        res_ready = 1'b0;
        if (res_valid !== 1'b0 || s_ready !== 1'b1) begin
            n_bad++; $display("FAIL hold_release: got rv=%b rdy=%b want 0/1", res_valid, s_ready);
        end
        n_cmp++;
    endtask

    task automatic test_timeout();
`ifdef MNIST_STREAM_TIMEOUT_EN
        int w0, rv_cyc;
        check_good_frame("to", 1, 1'b0);
        w0 = capcyc[ncap-1];
        rv_cyc = -1;
        for (int g = 0; g < 100; g++) begin
            if (res_valid) begin rv_cyc = cyc; break; end
            tick();
        end
        if (rv_cyc !== w0 + 16) begin n_bad++; $display("FAIL to_latency: got %0d want %0d", rv_cyc - w0, 16); end
        n_cmp++;
        if (res_index !== 4'hF || res_timeout !== 1'b1) begin
            n_bad++; $display("FAIL to_result: got idx=%h to=%b want f/1", res_index, res_timeout);
        end
        n_cmp++;
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        if (res_valid !== 1'b0 || s_ready !== 1'b1) begin
            n_bad++; $display("FAIL to_release: got rv=%b rdy=%b want 0/1", res_valid, s_ready);
        end
        n_cmp++;
`else
        int nrv;
        check_good_frame("nowd", 1, 1'b0);
        nrv = 0;
        for (int i = 0; i < 10000; i++) begin
            tick();
            if (res_valid) nrv++;
        end
        if (nrv !== 0) begin n_bad++; $display("FAIL nowd_rv: got %0d cycles want 0", nrv); end
        n_cmp++;
        if (busy !== 1'b1 || res_timeout !== 1'b0) begin
            n_bad++; $display("FAIL nowd_state: got busy=%b to=%b want 1/0", busy, res_timeout);
        end
        n_cmp++;
        apply_reset();
        if (s_ready !== 1'b1 || busy !== 1'b0) begin
            n_bad++; $display("FAIL nowd_reset: got rdy=%b busy=%b want 1/0", s_ready, busy);
        end
        n_cmp++;
`endif
    endtask

    initial begin
        test_reset();
        test_stream();
        test_result(4'h7, "result");
        test_frame_err();
        test_gaps();
        test_reset_mid_burst();
        test_result_hold();
        test_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
